// File: rtl/pulse_stretch.sv
// pulse_stretch: regenerates one-cycle strobes as output pulses that are
// HIGH_CYCLES wide and followed by at least GAP_CYCLES low cycles.
// Strobes that arrive while a pulse is running are counted and replayed
// back-to-back, up to MAX_PENDING. When the count is already at
// MAX_PENDING, a new strobe is dropped and a one-cycle overflow flag is raised.
//
// Optional feature macro: PULSE_RETRIGGER_EN
//   defined   : a strobe during HIGH restarts the high count, which extends
//               the current pulse; it does not change pending or overflow.
//   undefined : a strobe during HIGH is queued like any other busy strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no pulse in progress, waiting for pulse_in
// HIGH  | level_out high, cnt counts down the remaining high cycles
// GAP   | level_out low, cnt counts down the remaining gap cycles;
//       | on the last gap cycle a queued or simultaneous strobe
//       | starts the next pulse immediately
module pulse_stretch #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PENDING = 3,
    parameter int PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pulse_in,
    output logic          level_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int CMAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic            level_q, level_d;
    logic            overflow_q, overflow_d;
    logic            queue_req;

    // State, counter and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= '0;
            level_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Next state, counter and pending-queue update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overflow_d = 1'b0;
        queue_req  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end

            ST_HIGH: begin
`ifdef PULSE_RETRIGGER_EN
                if (pulse_in) begin
                    cnt_d = HIGH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                queue_req = pulse_in;
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end

            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d     = cnt_q - 1'b1;
                    queue_req = pulse_in;
                end else if (pending_q != '0) begin
                    // A strobe on this cycle replaces the one we dequeue.
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                    if (!pulse_in) begin
                        pending_d = pending_q - 1'b1;
                    end
                end else if (pulse_in) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                pending_d = '0;
            end
        endcase

        if (queue_req) begin
            if (pending_q < PEND_MAX) begin
                pending_d = pending_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Outputs: level follows the next state so that it is registered, and
    // busy is decoded from the state register alone.
    always_comb begin
        level_d = (state_d == ST_HIGH);
        busy    = (state_q == ST_HIGH) || (state_q == ST_GAP);
    end

    assign level_out = level_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Testbench for pulse_stretch with default parameters (4 high / 2 gap / 3 pending).
// Each table entry is a per-cycle pulse_in pattern with the expected
// level/busy/overflow waveforms written as bit masks over cycle numbers.
module tb_pulse_stretch;

    localparam int NCYC = 28;

    logic       clk;
    logic       rst_n;
    logic       pulse_in;
    logic       level_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       name;
        logic [31:0] pin;
        logic [31:0] lvl;
        logic [31:0] bsy;
        logic [31:0] ovf;
        int          pc0;
        int          pv0;
        int          pc1;
        int          pv1;
    } vec_t;

    typedef struct packed {
        logic lvl;
        logic bsy;
        logic ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    pulse_stretch #(
        .HIGH_CYCLES(4),
        .GAP_CYCLES (2),
        .MAX_PENDING(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] pin,
                                input logic [31:0] lvl, input logic [31:0] bsy,
                                input logic [31:0] ovf, input int pc0, input int pv0,
                                input int pc1, input int pv1);
        vec_t v;
        v.name = name; v.pin = pin; v.lvl = lvl; v.bsy = bsy; v.ovf = ovf;
        v.pc0 = pc0; v.pv0 = pv0; v.pc1 = pc1; v.pv1 = pv1;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input int got, input int want);
        tests++;
        if (got != want) begin
            failed++;
            $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, got, want);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t g;
        for (int t = 0; t < NCYC; t++) begin
            @(posedge clk);
            #1;
            pulse_in = v.pin[t];
            sb.push_back('{lvl: v.lvl[t], bsy: v.bsy[t], ovf: v.ovf[t]});
            @(negedge clk);
            e = sb.pop_front();
            g = '{lvl: level_out, bsy: busy, ovf: overflow};
            check({v.name, " lvl/busy/ovf"}, t, int'(g), int'(e));
            if (t == v.pc0) check({v.name, " pending"}, t, int'(pending), v.pv0);
            if (t == v.pc1) check({v.name, " pending"}, t, int'(pending), v.pv1);
        end
        pulse_in = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n    = 1'b0;
        pulse_in = 1'b0;

        vecs.push_back(mk("single", rng(0, 0), rng(1, 4), rng(1, 6), '0, 3, 0, 7, 0));
`ifndef PULSE_RETRIGGER_EN
        vecs.push_back(mk("queue", rng(0, 0) | rng(2, 2), rng(1, 4) | rng(7, 10),
                          rng(1, 12), '0, 3, 1, 7, 0));
        vecs.push_back(mk("overflow", rng(0, 4),
                          rng(1, 4) | rng(7, 10) | rng(13, 16) | rng(19, 22),
                          rng(1, 24), rng(5, 5), 4, 3, 7, 2));
        vecs.push_back(mk("simul", rng(0, 0) | rng(2, 2) | rng(6, 6),
                          rng(1, 4) | rng(7, 10) | rng(13, 16),
                          rng(1, 18), '0, 7, 1, 13, 0));
        vecs.push_back(mk("hi_queue", rng(0, 0) | rng(3, 3), rng(1, 4) | rng(7, 10),
                          rng(1, 12), '0, 4, 1, 7, 0));
`else
        vecs.push_back(mk("retrig", rng(0, 0) | rng(3, 3), rng(1, 7),
                          rng(1, 9), '0, 4, 0, 8, 0));
`endif
        vecs.push_back(mk("idle_gap", rng(0, 0) | rng(7, 7), rng(1, 4) | rng(8, 11),
                          rng(1, 6) | rng(8, 13), '0, 7, 0, 9, 0));
        vecs.push_back(mk("gap_queue", rng(0, 0) | rng(5, 5), rng(1, 4) | rng(7, 10),
                          rng(1, 12), '0, 6, 1, 7, 0));
        vecs.push_back(mk("last_gap", rng(0, 0) | rng(6, 6), rng(1, 4) | rng(7, 10),
                          rng(1, 12), '0, 6, 0, 7, 0));

        // Reset values before any clock edge.
        #2;
        check("rst level", 0, int'(level_out), 0);
        check("rst busy", 0, int'(busy), 0);
        check("rst pending", 0, int'(pending), 0);
        check("rst overflow", 0, int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in the middle of the second high cycle.
        @(posedge clk); #1; pulse_in = 1'b1;
        @(posedge clk); #1; pulse_in = 1'b0;
        @(posedge clk); #1;
        check("midpulse level", 2, int'(level_out), 1);
        check("midpulse busy", 2, int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async level", 2, int'(level_out), 0);
        check("async busy", 2, int'(busy), 0);
        check("async pending", 2, int'(pending), 0);
        check("async overflow", 2, int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk);
            #1;
            sb.push_back('{lvl: 1'b0, bsy: 1'b0, ovf: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            check("post-reset quiet", t, int'({level_out, busy, overflow}), int'(e));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
